// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
// Shared encodings for the data-memory arbiter:
//   arb_state_t : FSM state encoding (2 bits)
//   arb_gnt_t   : which requester won the IDLE grant this cycle
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_CORE_RD = 2'd1,
        ARB_LCD_RD  = 2'd2
    } arb_state_t;

    typedef enum logic [2:0] {
        GNT_NONE       = 3'd0,
        GNT_LCD_STARVE = 3'd1,
        GNT_CORE_WR    = 3'd2,
        GNT_CORE_RD    = 3'd3,
        GNT_LCD        = 3'd4
    } arb_gnt_t;

endpackage

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares the single data-RAM port between the core load/store stage and the
// LCD memory reader. The core has priority; a starvation counter lets the LCD
// preempt a pending core request after STARVE_LIMIT refused cycles.
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   core_rd_en/core_wr_en     core load/store request (held until core_stall==0)
//   core_addr/core_wdata      core address / store data
//   core_rdata/core_rvalid    load data passthrough / load-complete strobe
//   core_stall                freeze the core pipeline this cycle
//   lcd_rd_en/lcd_addr        LCD read request (level) / address
//   lcd_rdata/lcd_ack         registered LCD data / one-cycle update pulse
//   mem_addr/mem_wdata        RAM address / write data (0 when idle)
//   mem_rd_en/mem_wr_en       RAM strobes (grant cycle only)
//   mem_rdata                 RAM read data, valid RD_LATENCY cycles after mem_rd_en
//
// Optional feature (macro ARB_PERF_CNT_EN):
//   perf_core_stalls   cycles with core_stall==1
//   perf_lcd_preempts  LCD grants won through the starvation rule
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ARB_IDLE    | port free; grant decided combinationally this cycle
// ARB_CORE_RD | core read in flight; rvalid when lat_cnt reaches 0
// ARB_LCD_RD  | LCD read in flight; capture into lcd_rdata when lat_cnt is 0
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_rd_en,
    input  logic                  core_wr_en,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    output logic                  core_stall,
    input  logic                  lcd_rd_en,
    input  logic [ADDR_WIDTH-1:0] lcd_addr,
    output logic [DATA_WIDTH-1:0] lcd_rdata,
    output logic                  lcd_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_rd_en,
    output logic                  mem_wr_en,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_core_stalls,
    output logic [31:0]           perf_lcd_preempts
`endif
);

    localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [LAT_W-1:0]    LAT_INIT  = LAT_W'(RD_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_TC = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_state_t          state_nxt;
    arb_gnt_t            gnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                lat_done;
    logic                lcd_gnt;
    logic                core_req;
    logic                lcd_cap;

    assign lat_done = (lat_cnt == '0);
    assign lcd_gnt  = (gnt == GNT_LCD_STARVE) || (gnt == GNT_LCD);
    assign core_req = core_rd_en || core_wr_en;

    // Grant decision, only meaningful in IDLE. Suppressed during reset so no
    // RAM strobe escapes while rst is high.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst && state == ARB_IDLE) begin
            if (lcd_rd_en && starve_cnt == STARVE_TC) begin
                gnt = GNT_LCD_STARVE;
            end else if (core_wr_en) begin
                gnt = GNT_CORE_WR;
            end else if (core_rd_en) begin
                gnt = GNT_CORE_RD;
            end else if (lcd_rd_en) begin
                gnt = GNT_LCD;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (gnt == GNT_CORE_RD) begin
                    state_nxt = ARB_CORE_RD;
                end else if (lcd_gnt) begin
                    state_nxt = ARB_LCD_RD;
                end
            end
            ARB_CORE_RD, ARB_LCD_RD: begin
                if (lat_done) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Outputs. rvalid/capture are gated by rst so a read in flight when
    // reset arrives never completes.
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        core_rvalid = 1'b0;
        core_rdata  = '0;
        core_stall  = 1'b0;
        lcd_cap     = 1'b0;

        case (gnt)
            GNT_CORE_WR: begin
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
                mem_wr_en = 1'b1;
            end
            GNT_CORE_RD: begin
                mem_addr  = core_addr;
                mem_rd_en = 1'b1;
            end
            GNT_LCD_STARVE, GNT_LCD: begin
                mem_addr  = lcd_addr;
                mem_rd_en = 1'b1;
            end
            default: ;
        endcase

        if (!rst && lat_done) begin
            core_rvalid = (state == ARB_CORE_RD);
            lcd_cap     = (state == ARB_LCD_RD);
        end
        if (core_rvalid) begin
            core_rdata = mem_rdata;
        end

        // The core keeps stalling unless this cycle completes its access:
        // the write grant or the read-data cycle.
        if (!rst && core_req) begin
            core_stall = ((state != ARB_IDLE) && !core_rvalid) ||
                         lcd_gnt || (gnt == GNT_CORE_RD);
        end
    end

    // Read-latency down-counter, loaded on entry to either read state
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
            lat_cnt <= LAT_INIT;
        end else if (state != ARB_IDLE && !lat_done) begin
            lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Starvation counter: counts refused LCD cycles, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst || !lcd_rd_en || lcd_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_TC) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // LCD data register; ack lines up with the new data
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_rdata <= '0;
            lcd_ack   <= 1'b0;
        end else begin
            lcd_ack <= lcd_cap;
            if (lcd_cap) begin
                lcd_rdata <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_core_stalls  <= '0;
            perf_lcd_preempts <= '0;
        end else begin
            if (core_stall) begin
                perf_core_stalls <= perf_core_stalls + 32'd1;
            end
            if (gnt == GNT_LCD_STARVE) begin
                perf_lcd_preempts <= perf_lcd_preempts + 32'd1;
            end
        end
    end
`endif

endmodule
